// File: rtl/ssaes_pkg.sv
// Shared small-scale AES definitions: nibble width, sequencer FSM states and
// the default state size in nibbles.
package ssaes_pkg;

  localparam int NW      = 4;  // nibble width
  localparam int DEF_NIB = 4;  // default nibbles per state word

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : ssaes_pkg

// File: rtl/ark_sb_sequencer_if.sv
// Handshake bundle for ark_sb_sequencer: input word (state + key), output
// word and busy. The slave modport is the sequencer side.
interface ark_sb_sequencer_if
  import ssaes_pkg::*;
#(
  parameter int NIB = DEF_NIB
);

  logic                in_valid;
  logic                in_ready;
  logic [NW*NIB-1:0]   in_state;
  logic [NW*NIB-1:0]   in_key;
  logic                out_valid;
  logic                out_ready;
  logic [NW*NIB-1:0]   out_state;
  logic                busy;

  modport slave (
    input  in_valid, in_state, in_key, out_ready,
    output in_ready, out_valid, out_state, busy
  );

  modport master (
    output in_valid, in_state, in_key, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

endinterface : ark_sb_sequencer_if

// File: rtl/ark_sb_sequencer_subbytes.sv
// 4-bit small-scale AES S-box (SubBytes), purely combinational.
module ark_sb_sequencer_subbytes
  import ssaes_pkg::*;
(
  input  logic [NW-1:0] a_in,
  output logic [NW-1:0] b_out
);

  // Table lookup of the small-scale S-box
  always_comb begin
    b_out = 4'h0;
    case (a_in)
      4'h0: b_out = 4'h6;
      4'h1: b_out = 4'hB;
      4'h2: b_out = 4'h5;
      4'h3: b_out = 4'h4;
      4'h4: b_out = 4'h2;
      4'h5: b_out = 4'hE;
      4'h6: b_out = 4'h7;
      4'h7: b_out = 4'hA;
      4'h8: b_out = 4'h9;
      4'h9: b_out = 4'hD;
      4'hA: b_out = 4'hF;
      4'hB: b_out = 4'hC;
      4'hC: b_out = 4'h3;
      4'hD: b_out = 4'h1;
      4'hE: b_out = 4'h0;
      4'hF: b_out = 4'h8;
      default: b_out = 4'h0;
    endcase
  end

endmodule : ark_sb_sequencer_subbytes

// File: rtl/ark_sb_sequencer.sv
// AddRoundKey + nibble-serial SubBytes sequencer. Captures state ^ key, pushes
// one nibble per cycle through a single S-box and presents the collected word
// with valid/ready.
// Optional build macro ARK_SB_PIPE_EN: registers the S-box output, adding one
// cycle to the SUB phase (latency NIB+1 instead of NIB).
module ark_sb_sequencer
  import ssaes_pkg::*;
#(
  parameter int NIB = DEF_NIB
) (
  input  logic               clk,
  input  logic               rst,
  ark_sb_sequencer_if.slave  bus
);

  localparam int W    = NW * NIB;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx;
  logic [W-1:0]    work;
  logic [W-1:0]    result;
  logic [NW-1:0]   sb_in;
  logic [NW-1:0]   sb_out;
  logic            accept;
  logic            last_wr;

  assign accept        = (state_q == IDLE) && bus.in_valid;
  assign sb_in         = work[NW*int'(idx) +: NW];
  assign bus.out_state = result;

  ark_sb_sequencer_subbytes u_subbytes (
    .a_in  (sb_in),
    .b_out (sb_out)
  );

`ifdef ARK_SB_PIPE_EN
  logic [NW-1:0]   sb_q;
  logic [IDXW-1:0] wr_idx;
  logic            wr_vld;
  logic            feed_done;

  // SUB ends when the registered copy of the last nibble lands in result
  assign last_wr = wr_vld && (wr_idx == LAST);

  // Feed nibbles into the S-box register, then write them one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      work      <= '0;
      result    <= '0;
      sb_q      <= '0;
      wr_idx    <= '0;
      wr_vld    <= 1'b0;
      feed_done <= 1'b0;
    end else if (accept) begin
      work      <= bus.in_state ^ bus.in_key;
      idx       <= '0;
      wr_vld    <= 1'b0;
      feed_done <= 1'b0;
    end else if (state_q == SUB) begin
      wr_vld <= !feed_done;
      if (!feed_done) begin
        sb_q   <= sb_out;
        wr_idx <= idx;
        if (idx == LAST) feed_done <= 1'b1;
        else             idx       <= idx + 1'b1;
      end
      if (wr_vld) result[NW*int'(wr_idx) +: NW] <= sb_q;
    end
  end
`else
  // SUB ends on the cycle the last nibble is written
  assign last_wr = (state_q == SUB) && (idx == LAST);

  // Capture state ^ key, then write one substituted nibble per SUB cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      work   <= '0;
      result <= '0;
    end else if (accept) begin
      work <= bus.in_state ^ bus.in_key;
      idx  <= '0;
    end else if (state_q == SUB) begin
      result[NW*int'(idx) +: NW] <= sb_out;
      if (idx != LAST) idx <= idx + 1'b1;
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) state_d = SUB;
      end
      SUB: begin
        if (last_wr) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule : ark_sb_sequencer

// File: tb/tb_ark_sb_sequencer.sv
// Self-checking bench for ark_sb_sequencer: scoreboard of expected words,
// latency, backpressure, mid-operation reset and back-to-back handshakes.
module tb_ark_sb_sequencer;
  import ssaes_pkg::*;

  localparam int NIB = DEF_NIB;
  localparam int W   = NW * NIB;
`ifdef ARK_SB_PIPE_EN
  localparam int LAT = NIB + 1;
`else
  localparam int LAT = NIB;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ark_sb_sequencer_if #(.NIB(NIB)) bus ();

  ark_sb_sequencer #(.NIB(NIB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sb_q[$];

  function automatic logic [3:0] ref_sbox(input logic [3:0] x);
    logic [3:0] t [16] = '{4'h6, 4'hB, 4'h5, 4'h4, 4'h2, 4'hE, 4'h7, 4'hA,
                           4'h9, 4'hD, 4'hF, 4'hC, 4'h3, 4'h1, 4'h0, 4'h8};
    return t[x];
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] s, input logic [W-1:0] k);
    logic [W-1:0] w, r;
    w = s ^ k;
    r = '0;
    for (int i = 0; i < NIB; i++) r[4*i +: 4] = ref_sbox(w[4*i +: 4]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one word for exactly one edge
  task automatic drive_in(input logic [W-1:0] s, input logic [W-1:0] k);
    bus.in_valid = 1'b1;
    bus.in_state = s;
    bus.in_key   = k;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Bounded wait for out_valid; returns edges waited
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 64) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_state !== '0) begin errors++; $display("FAIL reset_out_state: got %h want 0", bus.out_state); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_vectors();
    logic [W-1:0] vs [7], vk [7], exp;
    int cyc;
    vs[0] = 16'h0000; vk[0] = 16'h0000;
    vs[1] = 16'h1234; vk[1] = 16'h0000;
    vs[2] = 16'hFFFF; vk[2] = 16'h0F0F;
    for (int i = 3; i < 7; i++) begin
      vs[i] = W'($urandom);
      vk[i] = W'($urandom);
    end
    for (int i = 0; i < 7; i++) begin
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL vec%0d_in_ready: got %b want 1", i, bus.in_ready); end
      case (i)
        0: sb_q.push_back(16'h6666);
        1: sb_q.push_back(16'hB542);
        2: sb_q.push_back(16'h8686);
        default: sb_q.push_back(model(vs[i], vk[i]));
      endcase
      drive_in(vs[i], vk[i]);
      checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL vec%0d_busy: got busy=%b in_ready=%b want 1/0", i, bus.busy, bus.in_ready); end
      wait_valid(cyc);
      checks++; if (cyc !== LAT) begin errors++; $display("FAIL vec%0d_latency: got %0d want %0d", i, cyc, LAT); end
      exp = sb_q.pop_front();
      checks++; if (bus.out_state !== exp) begin errors++; $display("FAIL vec%0d_out_state: got %h want %h", i, bus.out_state, exp); end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL vec%0d_release: got out_valid=%b in_ready=%b want 0/1", i, bus.out_valid, bus.in_ready); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp;
    int cyc;
    sb_q.push_back(16'h8686);
    drive_in(16'hFFFF, 16'h0F0F);
    wait_valid(cyc);
    checks++; if (cyc !== LAT) begin errors++; $display("FAIL bp_latency: got %0d want %0d", cyc, LAT); end
    exp = sb_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.in_state = 16'h1234;
      bus.in_key   = 16'h0000;
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_state !== exp || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b s=%h rdy=%b want 1/%h/0", i, bus.out_valid, bus.out_state, bus.in_ready, exp);
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL bp_release: got v=%b rdy=%b busy=%b want 0/1/0", bus.out_valid, bus.in_ready, bus.busy); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_ignored_input: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] exp;
    int cyc;
    drive_in(16'h1234, 16'h0000);
    tick(); tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_state !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got rdy=%b v=%b s=%h busy=%b want 1/0/0000/0", bus.in_ready, bus.out_valid, bus.out_state, bus.busy);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_output%0d: got %b want 0", i, bus.out_valid); end
    end
    sb_q.push_back(16'hB542);
    drive_in(16'h1234, 16'h0000);
    wait_valid(cyc);
    checks++; if (cyc !== LAT) begin errors++; $display("FAIL midrst_latency: got %0d want %0d", cyc, LAT); end
    exp = sb_q.pop_front();
    checks++; if (bus.out_state !== exp) begin errors++; $display("FAIL midrst_out_state: got %h want %h", bus.out_state, exp); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    int cyc;
    sb_q.push_back(model(16'hA5C3, 16'h3C5A));
    drive_in(16'hA5C3, 16'h3C5A);
    // out_ready while nothing is valid must not disturb the sequence
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    wait_valid(cyc);
    checks++; if (cyc + 1 !== LAT) begin errors++; $display("FAIL b2b_first_latency: got %0d want %0d", cyc + 1, LAT); end
    exp = sb_q.pop_front();
    checks++; if (bus.out_state !== exp) begin errors++; $display("FAIL b2b_first_state: got %h want %h", bus.out_state, exp); end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_state  = 16'h0F1E;
    bus.in_key    = 16'h7700;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_done: got %b want 0", bus.in_ready); end
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got rdy=%b v=%b want 1/0", bus.in_ready, bus.out_valid); end
    sb_q.push_back(model(16'h0F1E, 16'h7700));
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got busy=%b want 1", bus.busy); end
    wait_valid(cyc);
    checks++; if (cyc !== LAT) begin errors++; $display("FAIL b2b_second_latency: got %0d want %0d", cyc, LAT); end
    exp = sb_q.pop_front();
    checks++; if (bus.out_state !== exp) begin errors++; $display("FAIL b2b_second_state: got %h want %h", bus.out_state, exp); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.in_key    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ark_sb_sequencer
